// File: rtl/sfx_pkg.sv
// Shared types and helpers for the pong sound-effect player.
// Pong effect presets live here so the board top can wire them into sfx_player.
package sfx_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_e;

   typedef struct packed {
      logic       vld;
      logic [7:0] idx;
   } prio_t;

   localparam int unsigned HIT_HP    = 32'd12499;
   localparam int unsigned HIT_DUR   = 32'd2_500_000;
   localparam int unsigned WALL_HP   = 32'd24999;
   localparam int unsigned WALL_DUR  = 32'd2_500_000;
   localparam int unsigned SCORE_HP  = 32'd49999;
   localparam int unsigned SCORE_DUR = 32'd5_000_000;

   // Lowest set bit wins; index 0 is the highest priority.
   function automatic prio_t prio_sel(input logic [31:0] req);
      prio_t r;
      r.vld = 1'b0;
      r.idx = 8'd0;
      for (int i = 31; i >= 0; i--) begin
         if (req[i]) begin
            r.vld = 1'b1;
            r.idx = 8'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/sfx_tone_gen.sv
// Square-wave generator: latches a half-period on load and toggles the wave
// every hp+1 cycles while run is high.
module sfx_tone_gen
   import sfx_pkg::*;
#(
   parameter int HP_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_i,
   input  logic [HP_W-1:0] hp_in_i,
   input  logic            run_i,
   output logic            wave_o
);

   logic [HP_W-1:0] hp_q, hp_d;
   logic [HP_W-1:0] tone_cnt_q, tone_cnt_d;
   logic            wave_q, wave_d;

   // Next-state: load restarts the phase, run advances it.
   always_comb begin
      hp_d       = hp_q;
      tone_cnt_d = tone_cnt_q;
      wave_d     = wave_q;
      if (load_i) begin
         hp_d       = hp_in_i;
         tone_cnt_d = {HP_W{1'b0}};
         wave_d     = 1'b0;
      end else if (run_i) begin
         if (tone_cnt_q == hp_q) begin
            tone_cnt_d = {HP_W{1'b0}};
            wave_d     = ~wave_q;
         end else begin
            tone_cnt_d = tone_cnt_q + HP_W'(1);
         end
      end else begin
         wave_d = wave_q;
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         hp_q       <= {HP_W{1'b0}};
         tone_cnt_q <= {HP_W{1'b0}};
         wave_q     <= 1'b0;
      end else begin
         hp_q       <= hp_d;
         tone_cnt_q <= tone_cnt_d;
         wave_q     <= wave_d;
      end
   end

   assign wave_o = wave_q;

endmodule

// File: rtl/sfx_player.sv
// Multi-effect square-wave player with fixed-priority preemption.
// Define SFX_QUEUE_EN to add a one-deep pending slot for lower-priority triggers.
module sfx_player
   import sfx_pkg::*;
#(
   parameter int NUM_FX = 4,
   parameter int HP_W   = 16,
   parameter int DUR_W  = 23,
   parameter int ID_W   = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_FX-1:0]       trig_i,
   input  logic [NUM_FX*HP_W-1:0]  half_period_i,
   input  logic [NUM_FX*DUR_W-1:0] duration_i,
   output logic                    aud_pwm_o,
   output logic                    aud_sd_o,
   output logic                    busy_o,
   output logic [ID_W-1:0]         active_id_o,
   output logic                    done_o
);

   state_e            state_q, state_d;
   logic [NUM_FX-1:0] trig_q;
   logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;
   logic [ID_W-1:0]   active_id_q, active_id_d;
   logic              done_q, done_d;

   logic [NUM_FX-1:0] edge_s;
   prio_t             sel_s;
   logic              expire_s;
   logic              start_s;
   logic [7:0]        start_idx_s;
   logic [HP_W-1:0]   hp_sel_s;
   logic [DUR_W-1:0]  dur_sel_s;
   logic              busy_s;
   logic              wave_s;

`ifdef SFX_QUEUE_EN
   logic              pend_vld_q, pend_vld_d;
   logic [ID_W-1:0]   pend_id_q, pend_id_d;
`endif

   // Edge detect, arbitration and start decision.
   always_comb begin
      edge_s      = trig_i & ~trig_q;
      sel_s       = prio_sel(32'(edge_s));
      expire_s    = (state_q == PLAY) && (dur_cnt_q == DUR_W'(1));
      start_s     = 1'b0;
      start_idx_s = sel_s.idx;
`ifdef SFX_QUEUE_EN
      pend_vld_d  = pend_vld_q;
      pend_id_d   = pend_id_q;
`endif
      // A finished tone accepts any trigger; a running one only equal-or-higher priority.
      if (sel_s.vld && ((state_q == IDLE) || expire_s || (sel_s.idx <= 8'(active_id_q)))) begin
         start_s = 1'b1;
      end
`ifdef SFX_QUEUE_EN
      else if (sel_s.vld) begin
         if (!pend_vld_q || (sel_s.idx < 8'(pend_id_q))) begin
            pend_vld_d = 1'b1;
            pend_id_d  = ID_W'(sel_s.idx);
         end else begin
            pend_vld_d = pend_vld_q;
         end
      end else if (expire_s && pend_vld_q) begin
         start_s     = 1'b1;
         start_idx_s = 8'(pend_id_q);
         pend_vld_d  = 1'b0;
      end
`endif
      else begin
         start_s = 1'b0;
      end
      hp_sel_s  = half_period_i[start_idx_s*HP_W +: HP_W];
      dur_sel_s = duration_i[start_idx_s*DUR_W +: DUR_W];
   end

   // Next-state for the IDLE/PLAY controller and duration counter.
   always_comb begin
      state_d     = state_q;
      dur_cnt_d   = dur_cnt_q;
      active_id_d = active_id_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_s) begin
               state_d = PLAY;
            end else begin
               state_d = IDLE;
            end
         end
         PLAY: begin
            done_d    = expire_s;
            dur_cnt_d = dur_cnt_q - DUR_W'(1);
            if (start_s) begin
               state_d = PLAY;
            end else if (expire_s) begin
               state_d = IDLE;
            end else begin
               state_d = PLAY;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (start_s) begin
         dur_cnt_d   = (dur_sel_s == {DUR_W{1'b0}}) ? DUR_W'(1) : dur_sel_s;
         active_id_d = ID_W'(start_idx_s);
      end else begin
         active_id_d = active_id_q;
      end
   end

   // Controller registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         trig_q      <= {NUM_FX{1'b0}};
         dur_cnt_q   <= {DUR_W{1'b0}};
         active_id_q <= {ID_W{1'b0}};
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         trig_q      <= trig_i;
         dur_cnt_q   <= dur_cnt_d;
         active_id_q <= active_id_d;
         done_q      <= done_d;
      end
   end

`ifdef SFX_QUEUE_EN
   // Pending-slot registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_vld_q <= 1'b0;
         pend_id_q  <= {ID_W{1'b0}};
      end else begin
         pend_vld_q <= pend_vld_d;
         pend_id_q  <= pend_id_d;
      end
   end
`endif

   assign busy_s = (state_q == PLAY);

   sfx_tone_gen #(
      .HP_W (HP_W)
   ) u_tone (
      .clk     (clk),
      .rst     (rst),
      .load_i  (start_s),
      .hp_in_i (hp_sel_s),
      .run_i   (busy_s),
      .wave_o  (wave_s)
   );

   assign aud_pwm_o   = wave_s & busy_s;
   assign aud_sd_o    = busy_s;
   assign busy_o      = busy_s;
   assign active_id_o = active_id_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_sfx_player.sv
// Scoreboard bench for sfx_player: a tone-level reference model predicts every
// output cycle; a negedge monitor compares the DUT against the queued predictions.
module tb_sfx_player;

   localparam int NUM_FX = 4;
   localparam int HP_W   = 16;
   localparam int DUR_W  = 23;
   localparam int ID_W   = 2;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NUM_FX-1:0]       trig;
   logic [NUM_FX*HP_W-1:0]  half_period;
   logic [NUM_FX*DUR_W-1:0] duration;
   logic                    aud_pwm, aud_sd, busy, done;
   logic [ID_W-1:0]         active_id;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       busy;
      logic       pwm;
      logic [1:0] id;
      logic       done;
   } exp_t;

   exp_t sb[$];

   // Reference model state: tone-level view (remaining cycles, elapsed cycles).
   bit         m_play;
   int         m_id, m_rem, m_el, m_hp;
   logic [3:0] m_prev;
   bit         m_done;
   bit         m_pvld;
   int         m_pid;

   sfx_player #(
      .NUM_FX (NUM_FX),
      .HP_W   (HP_W),
      .DUR_W  (DUR_W),
      .ID_W   (ID_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .trig_i        (trig),
      .half_period_i (half_period),
      .duration_i    (duration),
      .aud_pwm_o     (aud_pwm),
      .aud_sd_o      (aud_sd),
      .busy_o        (busy),
      .active_id_o   (active_id),
      .done_o        (done)
   );

   always #5 clk = ~clk;

   function automatic int get_hp(int i);
      return int'(half_period[i*HP_W +: HP_W]);
   endfunction

   function automatic int get_dur(int i);
      int d;
      d = int'(duration[i*DUR_W +: DUR_W]);
      return (d == 0) ? 1 : d;
   endfunction

   // Reference model: predicts the outputs visible after this clock edge.
   always @(posedge clk) begin : model
      exp_t       e;
      logic [3:0] ed;
      int         w, st;
      bit         exp_now;
      if (rst) begin
         m_play = 0; m_id = 0; m_rem = 0; m_el = 0; m_hp = 0;
         m_prev = 4'b0000; m_done = 0; m_pvld = 0; m_pid = 0;
      end else begin
         ed = trig & ~m_prev;
         m_prev = trig;
         w = -1;
         for (int i = 3; i >= 0; i--) if (ed[i]) w = i;
         exp_now = m_play && (m_rem == 1);
         m_done = exp_now;
         st = -1;
         if (w >= 0 && (!m_play || exp_now || w <= m_id)) begin
            st = w;
         end else if (w >= 0) begin
`ifdef SFX_QUEUE_EN
            if (!m_pvld || w < m_pid) begin
               m_pvld = 1;
               m_pid  = w;
            end
`endif
         end else if (exp_now && m_pvld) begin
            st = m_pid;
            m_pvld = 0;
         end
         if (st >= 0) begin
            m_play = 1; m_id = st; m_rem = get_dur(st); m_el = 0; m_hp = get_hp(st);
         end else if (m_play) begin
            if (exp_now) m_play = 0;
            else begin
               m_rem--;
               m_el++;
            end
         end
      end
      e.busy = m_play;
      e.pwm  = m_play && (((m_el / (m_hp + 1)) % 2) == 1);
      e.id   = 2'(m_id);
      e.done = m_done;
      sb.push_back(e);
   end

   task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Monitor: pops one prediction per output cycle and compares.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("busy",      8'(busy),      8'(e.busy));
         chk("aud_sd",    8'(aud_sd),    8'(e.busy));
         chk("aud_pwm",   8'(aud_pwm),   8'(e.pwm));
         chk("active_id", 8'(active_id), 8'(e.id));
         chk("done",      8'(done),      8'(e.done));
      end
   end

   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_fx(int i, int hp, int d);
      half_period[i*HP_W +: HP_W] = HP_W'(hp);
      duration[i*DUR_W +: DUR_W]  = DUR_W'(d);
   endtask

   task automatic pulse(logic [3:0] t);
      trig = t;
      cyc(1);
      trig = 4'b0000;
   endtask

   initial begin
      rst = 1'b1;
      trig = 4'b0000;
      half_period = '0;
      duration = '0;
      cyc(3);
      rst = 1'b0;
      set_fx(0, 2, 30);
      set_fx(1, 1, 8);
      set_fx(2, 3, 10);
      set_fx(3, 0, 12);
      cyc(2);
      // single tone, then simultaneous triggers
      pulse(4'b0010); cyc(12);
      pulse(4'b1010); cyc(12);
      // held trigger
      trig = 4'b0100; cyc(50); trig = 4'b0000; cyc(5);
      // preemption of a long id 2 tone
      set_fx(2, 3, 100);
      pulse(4'b0100); cyc(19); pulse(4'b0001); cyc(40);
      // zero duration with hp=0, then hp=0 toggle run
      set_fx(1, 0, 0);
      pulse(4'b0010); cyc(4);
      set_fx(1, 0, 6);
      pulse(4'b0010); cyc(10);
      // retrigger mid-tone
      set_fx(1, 1, 8);
      pulse(4'b0010); cyc(3); pulse(4'b0010); cyc(15);
      // trigger landing on the expiry cycle
      pulse(4'b0010); cyc(7); pulse(4'b1000); cyc(20);
      // lower-priority triggers during id 0
      set_fx(0, 2, 30);
      pulse(4'b0001); cyc(3); pulse(4'b1000); cyc(3); pulse(4'b0100); cyc(60);
      // reset mid-tone
      pulse(4'b0100); cyc(5);
      rst = 1'b1; cyc(3); rst = 1'b0; cyc(5);
      // randomized traffic
      repeat (1500) begin
         if ($urandom_range(0, 19) == 0)
            set_fx($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 25));
         if ($urandom_range(0, 5) == 0) trig = 4'($urandom_range(0, 15));
         else if ($urandom_range(0, 2) == 0) trig = 4'b0000;
         rst = ($urandom_range(0, 249) == 0);
         cyc(1);
      end
      trig = 4'b0000;
      rst = 1'b0;
      cyc(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
